// File: rtl/uart_frame_parser.sv
// Framed-packet parser behind the UART byte receiver: SYNC, LEN, payload, CSUM.
// Payload is buffered and released downstream only after the XOR checksum matches.
module uart_frame_parser #(
  parameter int         CLK_FRE    = 50,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         MAX_LEN    = 16,
  parameter int         TIMEOUT_US = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int TO_CYC = CLK_FRE * TIMEOUT_US;
  localparam int CW     = $clog2(TO_CYC + 1);
  localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);
  localparam logic [CW-1:0] IDLE_1  = CW'(1);
  localparam logic [7:0]    LEN_MAX = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_SEND
  } state_t;

  state_t        state_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic [7:0]    out_data_q;
  logic          frame_ok_q;
  logic          frame_err_q;
  logic [1:0]    err_code_q;
  logic [7:0]    len_q;
  logic [7:0]    csum_q;
  logic [7:0]    wr_idx_q;
  logic [7:0]    rd_idx_q;
  logic [CW-1:0] idle_q;
  logic [7:0]    buf_q [MAX_LEN];

  logic       acc;
  logic       in_frame;
  logic       timeout;
  logic       xfer;
  logic [7:0] rd_idx_d;
  logic [7:0] csum_d;

  assign acc      = in_valid && in_ready_q;
  assign in_frame = state_q inside {S_LEN, S_PAYLOAD, S_CSUM};
  assign timeout  = in_frame && !acc && (idle_q == TO_LAST);
  assign xfer     = out_valid_q && out_ready;
  assign rd_idx_d = rd_idx_q + 8'd1;
  assign csum_d   = csum_q ^ in_data;

  always_ff @(posedge clk) begin
    if (state_q == S_PAYLOAD && acc)
      buf_q[wr_idx_q[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'd0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
      len_q       <= 8'd0;
      csum_q      <= 8'd0;
      wr_idx_q    <= 8'd0;
      rd_idx_q    <= 8'd0;
      idle_q      <= '0;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      in_ready_q  <= 1'b1;

      // A byte arriving on the limit cycle wins over the timeout.
      if (!in_frame || acc) begin
        idle_q <= '0;
      end else if (timeout) begin
        idle_q      <= '0;
        frame_err_q <= 1'b1;
        err_code_q  <= 2'd3;
        state_q     <= S_SYNC;
      end else begin
        idle_q <= idle_q + IDLE_1;
      end

      unique case (state_q)
        S_SYNC: begin
          if (acc && in_data == SYNC_BYTE)
            state_q <= S_LEN;
        end
        S_LEN: begin
          if (acc) begin
            if (in_data == 8'd0 || in_data > LEN_MAX) begin
              frame_err_q <= 1'b1;
              err_code_q  <= 2'd1;
              state_q     <= S_SYNC;
            end else begin
              len_q    <= in_data;
              csum_q   <= in_data;
              wr_idx_q <= 8'd0;
              state_q  <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (acc) begin
            csum_q   <= csum_d;
            wr_idx_q <= wr_idx_q + 8'd1;
            if (wr_idx_q == len_q - 8'd1)
              state_q <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (acc) begin
            if (in_data == csum_q) begin
              frame_ok_q  <= 1'b1;
              rd_idx_q    <= 8'd0;
              out_valid_q <= 1'b1;
              out_data_q  <= buf_q[0];
              out_last_q  <= (len_q == 8'd1);
              in_ready_q  <= 1'b0;
              state_q     <= S_SEND;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= 2'd2;
              state_q     <= S_SYNC;
            end
          end
        end
        S_SEND: begin
          if (xfer && out_last_q) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= S_SYNC;
          end else begin
            in_ready_q <= 1'b0;
            if (xfer) begin
              rd_idx_q   <= rd_idx_d;
              out_data_q <= buf_q[rd_idx_d[AW-1:0]];
              out_last_q <= (rd_idx_d == len_q - 8'd1);
            end
          end
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule
